// File: rtl/vga_text_term.sv
// Text-mode terminal: ASCII byte stream into a COLS x ROWS character buffer with a hardware scroll
// pointer, plus a two-stage pixel lookup pipeline feeding the font ROM. Optional macro: CURSOR_BLINK_EN.
module vga_text_term #(
    parameter int COLS   = 70,
    parameter int ROWS   = 30,
    parameter int CHAR_W = 9,
    parameter int CHAR_H = 16
`ifdef CURSOR_BLINK_EN
    ,
    parameter int BLINK_CYCLES = 25000000
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_char,
    output logic       in_ready,
    input  logic [9:0] h_addr,
    input  logic [9:0] v_addr,
    output logic [7:0] font_ascii,
    output logic [3:0] font_row,
    output logic [3:0] font_col,
    input  logic       font_bit,
    output logic       pixel_on,
    output logic [6:0] cursor_x,
    output logic [4:0] cursor_y
);
    localparam int CELLS = COLS * ROWS;
    localparam int AW    = $clog2(CELLS);

    typedef enum logic [1:0] {INIT, IDLE, SCROLL} state_t;

    state_t          state_r;
    logic [4:0]      top_r;
    logic [AW-1:0]   clr_cnt_r;
    logic [7:0]      mem_r [0:CELLS-1];

    logic            accept_s;
    logic            printable_s;
    logic [AW-1:0]   cur_addr_s;
    logic [4:0]      bottom_line_s;
    logic            we_s;
    logic            mem_we_s;
    logic [AW-1:0]   waddr_s;
    logic [7:0]      wdata_s;
    logic [6:0]      cx_nxt_s;
    logic            adv_s;

    logic [6:0]      ccol_s;
    logic [3:0]      gcol_s;
    logic [4:0]      rline_s;
    logic [3:0]      grow_s;
    logic            in_range_s;
    logic [AW-1:0]   raddr_s;
    logic            range_r;

    // Logical line to physical line through the scroll pointer.
    function automatic logic [4:0] phys_line(input logic [4:0] line, input logic [4:0] top);
        logic [5:0] sum;
        sum = {1'b0, line} + {1'b0, top};
        sum = (sum >= 6'(ROWS)) ? (sum - 6'(ROWS)) : sum;
        return sum[4:0];
    endfunction

    function automatic logic [AW-1:0] cell_addr(input logic [4:0] pline, input logic [6:0] col);
        return AW'(pline) * AW'(COLS) + AW'(col);
    endfunction

    assign accept_s      = in_valid & in_ready;
    assign printable_s   = (in_char >= 8'h20) && (in_char <= 8'h7E);
    assign cur_addr_s    = cell_addr(phys_line(cursor_y, top_r), cursor_x);
    // top has already advanced on SCROLL entry, so this is the line that just left the top of the screen.
    assign bottom_line_s = phys_line(5'(ROWS - 1), top_r);
    assign mem_we_s      = we_s & rst_n;

    // Byte decode and buffer write-port selection.
    always_comb begin
        we_s     = 1'b0;
        waddr_s  = {AW{1'b0}};
        wdata_s  = 8'h20;
        cx_nxt_s = cursor_x;
        adv_s    = 1'b0;
        case (state_r)
            INIT: begin
                we_s    = 1'b1;
                waddr_s = clr_cnt_r;
            end
            IDLE: begin
                if (accept_s) begin
                    if (printable_s) begin
                        we_s    = 1'b1;
                        waddr_s = cur_addr_s;
                        wdata_s = in_char;
                        if (cursor_x == 7'(COLS - 1)) begin
                            cx_nxt_s = 7'd0;
                            adv_s    = 1'b1;
                        end else begin
                            cx_nxt_s = cursor_x + 7'd1;
                        end
                    end else if (in_char == 8'h0A) begin
                        cx_nxt_s = 7'd0;
                        adv_s    = 1'b1;
                    end else if (in_char == 8'h0D) begin
                        cx_nxt_s = 7'd0;
                    end else if ((in_char == 8'h08) && (cursor_x != 7'd0)) begin
                        cx_nxt_s = cursor_x - 7'd1;
                        we_s     = 1'b1;
                        waddr_s  = cur_addr_s - {{(AW-1){1'b0}}, 1'b1};
                    end else begin
                        cx_nxt_s = cursor_x;
                    end
                end else begin
                    cx_nxt_s = cursor_x;
                end
            end
            SCROLL: begin
                we_s    = 1'b1;
                waddr_s = cell_addr(bottom_line_s, clr_cnt_r[6:0]);
            end
            default: begin
                we_s = 1'b0;
            end
        endcase
    end

    // Character buffer write port.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[waddr_s] <= wdata_s;
        end
    end

    // Control FSM: clear, accept bytes, scroll.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= INIT;
            clr_cnt_r <= {AW{1'b0}};
            top_r     <= 5'd0;
            cursor_x  <= 7'd0;
            cursor_y  <= 5'd0;
            in_ready  <= 1'b0;
        end else begin
            case (state_r)
                INIT: begin
                    if (clr_cnt_r == AW'(CELLS - 1)) begin
                        state_r   <= IDLE;
                        clr_cnt_r <= {AW{1'b0}};
                        in_ready  <= 1'b1;
                    end else begin
                        clr_cnt_r <= clr_cnt_r + {{(AW-1){1'b0}}, 1'b1};
                    end
                end
                IDLE: begin
                    cursor_x <= cx_nxt_s;
                    if (adv_s) begin
                        if (cursor_y < 5'(ROWS - 1)) begin
                            cursor_y <= cursor_y + 5'd1;
                        end else begin
                            state_r   <= SCROLL;
                            in_ready  <= 1'b0;
                            clr_cnt_r <= {AW{1'b0}};
                            top_r     <= (top_r == 5'(ROWS - 1)) ? 5'd0 : top_r + 5'd1;
                        end
                    end
                end
                SCROLL: begin
                    if (clr_cnt_r == AW'(COLS - 1)) begin
                        state_r   <= IDLE;
                        clr_cnt_r <= {AW{1'b0}};
                        in_ready  <= 1'b1;
                    end else begin
                        clr_cnt_r <= clr_cnt_r + {{(AW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r   <= INIT;
                    clr_cnt_r <= {AW{1'b0}};
                    in_ready  <= 1'b0;
                end
            endcase
        end
    end

    assign ccol_s     = 7'(h_addr / 10'(CHAR_W));
    assign gcol_s     = 4'(h_addr % 10'(CHAR_W));
    assign rline_s    = 5'(v_addr / 10'(CHAR_H));
    assign grow_s     = 4'(v_addr % 10'(CHAR_H));
    assign in_range_s = (h_addr < 10'(COLS * CHAR_W)) && (v_addr < 10'(ROWS * CHAR_H));
    assign raddr_s    = in_range_s ? cell_addr(phys_line(rline_s, top_r), ccol_s) : {AW{1'b0}};

    // Pipeline stage 1: buffer read and glyph coordinates to the font ROM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            font_ascii <= 8'h00;
            font_row   <= 4'd0;
            font_col   <= 4'd0;
            range_r    <= 1'b0;
        end else begin
            font_ascii <= in_range_s ? mem_r[raddr_s] : 8'h20;
            font_row   <= grow_s;
            font_col   <= gcol_s;
            range_r    <= in_range_s;
        end
    end

`ifdef CURSOR_BLINK_EN
    localparam int BW = $clog2(BLINK_CYCLES);
    logic [BW-1:0] blink_cnt_r;
    logic          blink_phase_r;
    logic          cur_hit_r;

    // Blink phase generator and cursor-cell tag travelling with the pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt_r   <= {BW{1'b0}};
            blink_phase_r <= 1'b0;
            cur_hit_r     <= 1'b0;
        end else begin
            if (blink_cnt_r == BW'(BLINK_CYCLES - 1)) begin
                blink_cnt_r   <= {BW{1'b0}};
                blink_phase_r <= ~blink_phase_r;
            end else begin
                blink_cnt_r <= blink_cnt_r + {{(BW-1){1'b0}}, 1'b1};
            end
            cur_hit_r <= in_range_s && (ccol_s == cursor_x) && (rline_s == cursor_y);
        end
    end
`endif

    // Pipeline stage 2: registered foreground pixel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pixel_on <= 1'b0;
        end else begin
`ifdef CURSOR_BLINK_EN
            pixel_on <= (font_bit & range_r) ^ (blink_phase_r & cur_hit_r);
`else
            pixel_on <= font_bit & range_r;
`endif
        end
    end

endmodule

// File: tb/tb_vga_text_term.sv
// Bench for vga_text_term: randomized byte/pixel stimulus against a logical-screen reference model,
// with a queue-based scoreboard checking the read pipeline.
module tb_vga_text_term;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_char = 8'h00;
    logic       in_ready;
    logic [9:0] h_addr = 10'd0;
    logic [9:0] v_addr = 10'd0;
    logic [7:0] font_ascii;
    logic [3:0] font_row;
    logic [3:0] font_col;
    logic       font_bit;
    logic       pixel_on;
    logic [6:0] cursor_x;
    logic [4:0] cursor_y;

    vga_text_term dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_char(in_char), .in_ready(in_ready),
        .h_addr(h_addr), .v_addr(v_addr), .font_ascii(font_ascii), .font_row(font_row),
        .font_col(font_col), .font_bit(font_bit), .pixel_on(pixel_on),
        .cursor_x(cursor_x), .cursor_y(cursor_y)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: screen held by logical line, scrolling shifts the lines.
    logic [7:0] scr [30][70];
    int cx = 0;
    int cy = 0;

    typedef struct {
        int         due;
        logic [7:0] a;
        logic [3:0] r;
        logic [3:0] c;
        logic       rng;
        logic       p;
    } exp_t;
    exp_t fq[$];
    exp_t pq[$];

    // Font ROM stand-in: space is blank, other glyphs a fixed bit pattern.
    function automatic logic font_fn(input logic [7:0] a, input logic [3:0] r, input logic [3:0] c);
        logic [7:0] t;
        t = a ^ {r, c};
        if (a == 8'h20) return 1'b0;
        return t[0] ^ t[2] ^ t[5] ^ r[0];
    endfunction

    assign font_bit = font_fn(font_ascii, font_row, font_col);

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_model();
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 70; c++) scr[r][c] = 8'h20;
        cx = 0;
        cy = 0;
    endtask

    task automatic model_adv();
        if (cy < 29) cy++;
        else begin
            for (int r = 0; r < 29; r++)
                for (int c = 0; c < 70; c++) scr[r][c] = scr[r+1][c];
            for (int c = 0; c < 70; c++) scr[29][c] = 8'h20;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            scr[cy][cx] = b;
            cx++;
            if (cx == 70) begin cx = 0; model_adv(); end
        end else if (b == 8'h0A) begin
            cx = 0;
            model_adv();
        end else if (b == 8'h0D) begin
            cx = 0;
        end else if (b == 8'h08) begin
            if (cx > 0) begin cx--; scr[cy][cx] = 8'h20; end
        end
    endtask

    function automatic logic [7:0] model_ascii(input int h, input int v);
        if (h >= 630 || v >= 480) return 8'h20;
        return scr[v/16][h/9];
    endfunction

    // Called at a negedge; returns at a negedge.
    task automatic send(input logic [7:0] b);
        int w = 0;
        while (!in_ready && w < 300) begin @(negedge clk); w++; end
        if (!in_ready) begin chk("ready_timeout", int'(in_ready), 1); return; end
        in_valid = 1'b1;
        in_char  = b;
        @(posedge clk);
        #1 in_valid = 1'b0;
        model_byte(b);
        @(negedge clk);
        chk("cursor_x", cursor_x, cx);
        chk("cursor_y", cursor_y, cy);
    endtask

    task automatic probe(input int h, input int v);
        exp_t e;
        e.rng = (h < 630) && (v < 480);
        e.a   = model_ascii(h, v);
        e.r   = 4'(v % 16);
        e.c   = 4'(h % 9);
        e.p   = e.rng ? font_fn(e.a, e.r, e.c) : 1'b0;
        h_addr = 10'(h);
        v_addr = 10'(v);
        e.due = cyc + 1;
        fq.push_back(e);
        e.due = cyc + 2;
        pq.push_back(e);
        @(negedge clk);
    endtask

    task automatic reset_and_init();
        int cnt = 0;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_cursor_x", cursor_x, 0);
        chk("rst_cursor_y", cursor_y, 0);
        chk("rst_pixel_on", pixel_on, 0);
        chk("rst_font_ascii", font_ascii, 0);
        chk("rst_font_row", font_row, 0);
        chk("rst_font_col", font_col, 0);
        rst_n = 1'b1;
        clear_model();
        while (cnt < 3000) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (in_ready) break;
        end
        chk("init_cycles", cnt, 2100);
    endtask

    // Newline at the bottom line, counting the cycles the engine is busy scrolling.
    task automatic bottom_newline(input int wait_cycles, output int busy);
        busy = 0;
        in_valid = 1'b1;
        in_char  = 8'h0A;
        @(posedge clk);
        #1 in_valid = 1'b0;
        model_byte(8'h0A);
        while (busy < wait_cycles) begin
            @(negedge clk);
            if (in_ready) break;
            busy++;
        end
    endtask

    // Scoreboard monitor: checks each pipeline output when it falls due.
    always @(negedge clk) begin : mon
        exp_t e;
        while (fq.size() > 0 && fq[0].due <= cyc) begin
            e = fq.pop_front();
            chk("font_due", e.due, cyc);
            chk("font_ascii", font_ascii, e.a);
            if (e.rng) begin
                chk("font_row", font_row, e.r);
                chk("font_col", font_col, e.c);
            end
        end
        while (pq.size() > 0 && pq[0].due <= cyc) begin
            e = pq.pop_front();
            chk("pixel_due", e.due, cyc);
            chk("pixel_on", pixel_on, e.p);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy;
        int b;
        repeat (3) @(negedge clk);
        reset_and_init();

        // Blank screen after clear.
        probe(0, 0);
        probe(629, 479);
        for (int i = 0; i < 150; i++) probe($urandom_range(0, 629), $urandom_range(0, 479));

        send(8'h41);
        probe(3, 5);

        send(8'h0D);
        for (int i = 0; i < 70; i++) send(8'h42);
        chk("wrap_cursor_x", cursor_x, 0);
        chk("wrap_cursor_y", cursor_y, 1);
        probe(9 * 69 + 1, 0);
        probe(630, 0);
        probe(5, 480);

        send(8'h08);
        for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
        send(8'h08);
        chk("bs_cursor_x", cursor_x, 4);
        probe(4 * 9 + 2, 16 + 7);
        probe(3 * 9, 16);

        // Random byte stream, including scrolls.
        for (int i = 0; i < 400; i++) begin
            b = $urandom_range(0, 99);
            if (b < 70)      send(8'($urandom_range(32, 126)));
            else if (b < 78) send(8'h0A);
            else if (b < 84) send(8'h0D);
            else if (b < 94) send(8'h08);
            else             send(8'($urandom_range(0, 255)));
        end
        for (int i = 0; i < 300; i++) probe($urandom_range(0, 700), $urandom_range(0, 520));

        // Directed scroll with 'Z' on line 1.
        reset_and_init();
        send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h20);
        send(8'h5A);
        send(8'h0D);
        for (int i = 0; i < 28; i++) send(8'h0A);
        chk("pre_scroll_y", cursor_y, 29);
        bottom_newline(200, busy);
        chk("scroll_busy", busy, 70);
        chk("scroll_cursor_x", cursor_x, 0);
        chk("scroll_cursor_y", cursor_y, 29);
        probe(5 * 9 + 4, 3);
        for (int c = 0; c < 70; c++) probe(c * 9 + (c % 9), 29 * 16 + (c % 16));

        // Reset in the middle of a scroll.
        bottom_newline(30, busy);
        chk("mid_scroll_busy", busy, 30);
        reset_and_init();
        send(8'h51);
        probe(2, 2);
        probe(9 + 2, 2);

        repeat (4) @(negedge clk);
        chk("queue_drain", fq.size() + pq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/vga_text_term.md
Name: vga_text_term

Overview:
- Text-mode terminal engine for the VGA path.
- Write side accepts an ASCII byte stream over valid/ready into a 70x30 character buffer, with cursor, wrap, newline, backspace and hardware scroll.
- Read side maps the VGA timing generator's pixel coordinates to (ascii, row, col) lookups on the font ROM and returns the registered pixel bit.
- Sits between the character source (keyboard/UART) and the font ROM / VGA colour mux.

Parameters:
- COLS, 70, characters per line.
- ROWS, 30, lines per screen.
- CHAR_W, 9, glyph width in pixels (font columns 0..CHAR_W-1).
- CHAR_H, 16, glyph height in pixels (font rows 0..15).
- BLINK_CYCLES, 25000000, half-period of cursor blink (used only with CURSOR_BLINK_EN).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  character byte valid.
- in_char  in  8  ASCII byte.
- in_ready  out  1  engine can accept a byte this cycle.
- h_addr  in  10  current pixel x from VGA timing.
- v_addr  in  10  current pixel y from VGA timing.
- font_ascii  out  8  glyph code to font ROM.
- font_row  out  4  glyph pixel row to font ROM.
- font_col  out  4  glyph pixel column to font ROM.
- font_bit  in  1  ROM pixel bit (combinational from font_* outputs).
- pixel_on  out  1  foreground pixel for (h_addr,v_addr) two cycles earlier.
- cursor_x  out  7  cursor column.
- cursor_y  out  5  cursor logical line.

Behaviour:
- Reset values: in_ready=0, pixel_on=0, font_ascii=0, font_row=0, font_col=0, cursor_x=0, cursor_y=0, top=0, state=INIT, clear counter=0.
- Buffer: COLS*ROWS bytes, one write port and one synchronous read port.
  - Physical line for logical line L is (L+top) mod ROWS.
  - Same-cycle read/write of one cell returns old data.
- FSM states: INIT, IDLE, SCROLL.
  - INIT: writes 0x20 to every cell, one cell per cycle (COLS*ROWS cycles), in_ready=0, then IDLE.
  - IDLE: in_ready=1; a byte is consumed on in_valid&&in_ready.
  - SCROLL: top <= (top+1) mod ROWS on entry; clears the new bottom physical line with 0x20 over COLS cycles; in_ready=0; then IDLE. cursor_y stays ROWS-1.
- Byte handling (IDLE only, one per cycle):
  - 0x20..0x7E: write at cursor, cursor_x+1. If it reaches COLS: cursor_x=0 and advance line.
  - 0x0A: cursor_x=0, advance line.
  - 0x0D: cursor_x=0.
  - 0x08: if cursor_x>0, cursor_x-1 and write 0x20 at the new position; at cursor_x=0 no-op (no reverse line wrap).
  - Any other byte: consumed, no effect.
- Advance line: if cursor_y<ROWS-1 then cursor_y+1, else enter SCROLL.
- Read pipeline:
  - Cycle 0: char column = h_addr/CHAR_W, glyph column = h_addr%CHAR_W, line = v_addr/CHAR_H, glyph row = v_addr%CHAR_H. Issue buffer read; register glyph row/col and an in-range flag.
  - Cycle 1: font_ascii = buffer data; font_row and font_col valid.
  - Cycle 2: pixel_on <= font_bit & in_range.
  - Constant divide/modulo may be combinational.
- Out of range: h_addr>=COLS*CHAR_W or v_addr>=ROWS*CHAR_H forces pixel_on=0 and font_ascii=0x20.
- The read side runs in every state. During INIT, cells not yet cleared display as their current contents.
- rst_n low at any time, including mid-INIT or mid-SCROLL, restarts INIT from cell 0 next cycle.

Optional Feature:
- Macro CURSOR_BLINK_EN.
- Defined: a counter toggles a blink phase every BLINK_CYCLES cycles. While the phase is 1 and the cell being rendered equals (cursor_x, cursor_y), pixel_on is inverted.
- Undefined: no counter, cursor not rendered, pixel_on exactly as above.

Test Plan:
- Reset, then release rst_n -> in_ready=0 for exactly 2100 cycles, then 1; pixel_on=0 for all in-range (h,v) scanned afterward.
- Send 0x41; drive h_addr=3, v_addr=5 -> one cycle later font_ascii=0x41, font_row=5, font_col=3; next cycle pixel_on equals font_bit; cursor_x=1.
- Send 70 bytes 0x42 -> cursor=(0,1); h_addr=9*69+1, v_addr=0 returns font_ascii=0x42; h_addr=630 -> pixel_on=0.
- At cursor_y=29 with line 1 holding 'Z', send 0x0A -> in_ready=0 for 70 cycles, cursor=(0,29); v_addr=0 at the 'Z' column shows font_ascii=0x5A; line 29 is all 0x20.
- Backspace at cursor_x=0 -> no change; at cursor_x=5 -> cursor_x=4 and cell 4 reads 0x20.
- Assert rst_n=0 for one cycle mid-SCROLL -> cursor=(0,0), top=0, full 2100-cycle INIT repeats.
